regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised, clocked multi-read-port register file for the MCU CPU core; successor to the single-port combinational register store.
- Holds NUM_REGS general registers, with the last index acting as the program counter, plus a CPSR flags register.
- Sits between decode (read addresses) and writeback/branch logic; feeds operands to the ALU and the PC to fetch.

Parameters:
- DATA_W, 32, register width in bits (must be ≥ 8 and a multiple of 4).
- NUM_REGS, 16, number of architectural registers; index NUM_REGS-1 is the PC.
- NUM_RD, 2, number of independent read ports.
- RESET_PC, 0, PC value loaded on reset (must be word-aligned).
- PC_READ_OFS, 8, offset added to the PC when the PC index is read through a read port.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W]. ADDR_W = clog2(NUM_REGS).
- rd_data  out  NUM_RD*DATA_W  packed read data; port i uses bits [i*DATA_W +: DATA_W].
- wr_en  in  1  write enable for the writeback port.
- wr_addr  in  ADDR_W  writeback register index.
- wr_data  in  DATA_W  writeback data.
- pc_inc  in  1  advance PC by 4 this cycle.
- pc  out  DATA_W  current PC (raw, no offset).
- flags_we  in  1  update CPSR flags.
- flags_in  in  4  {N,Z,C,V}.
- cpsr  out  DATA_W  CPSR; bits [DATA_W-1:DATA_W-4] = N,Z,C,V; all other bits 0.

Behaviour:
- Reset (reset_n low, asynchronous): all general registers = 0; PC = RESET_PC; CPSR = 0. Outputs reflect these values immediately, without waiting for a clock edge. Deassertion takes effect at the next clk edge.
- Reads are combinational from current state; zero-cycle latency.
  - rd_addr = NUM_REGS-1 returns pc + PC_READ_OFS, modulo 2^DATA_W.
  - Out-of-range indices (NUM_REGS not a power of 2) return 0.
- Writes take effect on the rising edge when wr_en = 1. Out-of-range wr_addr is ignored.
- PC update priority, per edge:
  1. wr_en with wr_addr = NUM_REGS-1: PC = {wr_data[DATA_W-1:2], 2'b00}. This wins over pc_inc.
  2. Otherwise, if pc_inc: PC = PC + 4, wrapping modulo 2^DATA_W.
  3. Otherwise PC holds.
- The PC lives only in the dedicated PC register; there is no duplicate array entry.
- flags_we = 1: CPSR[DATA_W-1:DATA_W-4] = flags_in on the edge. A write to the PC and a flags update in the same cycle are independent; both apply.
- Multiple read ports addressing the same register all return the same value.
- A read of a register being written in the same cycle returns the old value (pre-edge), unless the optional feature below is compiled in.
- No X propagation: every output is defined from reset onward.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding. When wr_en = 1 and rd_addr of port i equals wr_addr (in range), rd_data of port i = wr_data in the same cycle.
  - For the PC index, the forwarded value is the aligned wr_data + PC_READ_OFS.
  - The CPSR is not bypassed.
- Undefined: no forwarding; reads return the registered value only.

Decomposition:
- Shared package regfile_pkg holds:
  - CPSR bit-position constants N_BIT, Z_BIT, C_BIT, V_BIT (relative to the MSB).
  - The PC_INCR = 4 constant.
  - A typedef for the 4-bit flags struct {n,z,c,v}.
  - The clog2-based ADDR_W helper function.
- One natural sub-module, regfile_rd_port: the per-port read mux, PC offset and optional bypass logic; instantiated NUM_RD times in a generate loop.

Test Plan:
- Reset: assert reset_n low mid-cycle with no clock edge -> pc = RESET_PC (0x0), cpsr = 0, all rd_data = 0 immediately.
- Write/read: write 0xDEADBEEF to r3, then read r3 on port 0 and r3 on port 1 next cycle -> both = 0xDEADBEEF; a same-cycle read returns 0 without the macro, 0xDEADBEEF with REGFILE_BYPASS_EN.
- PC: pc_inc for 3 cycles from 0 -> pc = 0xC; reading r15 -> 0x14. With PC = 0xFFFFFFFC and pc_inc -> pc = 0x0.
- PC priority: same cycle wr_en, wr_addr = 15, wr_data = 0x1003, pc_inc = 1 -> pc = 0x1000.
- Flags: flags_we with flags_in = 4'b1010 together with a write to r15 -> cpsr = 0xA0000000 and pc updated; flags_we = 0 on the next cycle -> cpsr holds.
- Parametrisation: DATA_W = 16, NUM_REGS = 8, NUM_RD = 3; write to r7 = 0x0101 -> pc = 0x0100; all three ports reading r7 -> 0x0108.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants, flag struct and address-width helper for the multi-port register file.
package regfile_pkg;

    // CPSR flag positions, counted down from the MSB of the register.
    localparam int unsigned N_BIT = 0;
    localparam int unsigned Z_BIT = 1;
    localparam int unsigned C_BIT = 2;
    localparam int unsigned V_BIT = 3;

    localparam int unsigned PC_INCR = 4;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    function automatic int unsigned addr_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: register select, PC read offset and, when
// REGFILE_BYPASS_EN is defined, write-through forwarding from the writeback port.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned PC_READ_OFS = 8,
    localparam int unsigned ADDR_W     = addr_w(NUM_REGS)
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] gpr_i [NUM_REGS-1],
    input  logic [DATA_W-1:0] pc_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int unsigned PC_IDX = NUM_REGS - 1;

    logic is_pc;
    logic in_gpr;

    assign is_pc  = (addr_i == ADDR_W'(PC_IDX));
    assign in_gpr = (addr_i <  ADDR_W'(PC_IDX));

`ifdef REGFILE_BYPASS_EN
    logic fwd_hit;
    assign fwd_hit = wr_en_i && (wr_addr_i == addr_i) && (is_pc || in_gpr);
`else
    logic unused_fwd;
    assign unused_fwd = ^{wr_en_i, wr_addr_i, wr_data_i};
`endif

    always_comb begin
        rd_data_o = '0;
        if (is_pc) begin
            rd_data_o = pc_i + DATA_W'(PC_READ_OFS);
        end else if (in_gpr) begin
            rd_data_o = gpr_i[addr_i];
        end
`ifdef REGFILE_BYPASS_EN
        // Forwarded PC sees the same alignment the PC register applies on write.
        if (fwd_hit) begin
            rd_data_o = is_pc ? ({wr_data_i[DATA_W-1:2], 2'b00} + DATA_W'(PC_READ_OFS))
                              : wr_data_i;
        end
`endif
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with dedicated PC and CPSR flags.
// Optional write-through forwarding is compiled in with REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned NUM_RD      = 2,
    parameter int unsigned RESET_PC    = 0,
    parameter int unsigned PC_READ_OFS = 8,
    localparam int unsigned ADDR_W     = addr_w(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pc_inc,
    output logic [DATA_W-1:0]        pc,
    input  logic                     flags_we,
    input  logic [3:0]               flags_in,
    output logic [DATA_W-1:0]        cpsr
);

    localparam int unsigned PC_IDX = NUM_REGS - 1;
    localparam int unsigned NGPR   = NUM_REGS - 1;

    logic [DATA_W-1:0] gpr_q [NGPR];
    logic [DATA_W-1:0] gpr_d [NGPR];
    logic [DATA_W-1:0] pc_q, pc_d;
    flags_t            flags_q, flags_d;

    logic pc_wr;
    logic gpr_wr;

    assign pc_wr  = wr_en && (wr_addr == ADDR_W'(PC_IDX));
    assign gpr_wr = wr_en && (wr_addr <  ADDR_W'(PC_IDX));

    always_comb begin
        gpr_d   = gpr_q;
        pc_d    = pc_q;
        flags_d = flags_q;
        if (gpr_wr) begin
            gpr_d[wr_addr] = wr_data;
        end
        // An explicit PC write overrides the sequential increment.
        if (pc_wr) begin
            pc_d = {wr_data[DATA_W-1:2], 2'b00};
        end else if (pc_inc) begin
            pc_d = pc_q + DATA_W'(PC_INCR);
        end
        if (flags_we) begin
            flags_d = flags_t'(flags_in);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NGPR; i++) begin
                gpr_q[i] <= '0;
            end
            pc_q    <= DATA_W'(RESET_PC);
            flags_q <= '0;
        end else begin
            gpr_q   <= gpr_d;
            pc_q    <= pc_d;
            flags_q <= flags_d;
        end
    end

    assign pc = pc_q;

    always_comb begin
        cpsr                   = '0;
        cpsr[DATA_W-1 - N_BIT] = flags_q.n;
        cpsr[DATA_W-1 - Z_BIT] = flags_q.z;
        cpsr[DATA_W-1 - C_BIT] = flags_q.c;
        cpsr[DATA_W-1 - V_BIT] = flags_q.v;
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        regfile_rd_port #(
            .DATA_W      (DATA_W),
            .NUM_REGS    (NUM_REGS),
            .PC_READ_OFS (PC_READ_OFS)
        ) u_port (
            .addr_i    (rd_addr[g*ADDR_W +: ADDR_W]),
            .gpr_i     (gpr_q),
            .pc_i      (pc_q),
            .wr_en_i   (wr_en),
            .wr_addr_i (wr_addr),
            .wr_data_i (wr_data),
            .rd_data_o (rd_data[g*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default 32-bit instance plus a 16-bit/8-reg/3-port instance.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset_n;

    logic [7:0]  rd_addr;
    logic [63:0] rd_data;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        pc_inc;
    logic [31:0] pc;
    logic        flags_we;
    logic [3:0]  flags_in;
    logic [31:0] cpsr;

    logic [8:0]  rd_addr16;
    logic [47:0] rd_data16;
    logic        wr_en16;
    logic [2:0]  wr_addr16;
    logic [15:0] wr_data16;
    logic        pc_inc16;
    logic [15:0] pc16;
    logic        flags_we16;
    logic [3:0]  flags_in16;
    logic [15:0] cpsr16;

    regfile_mp u_dut (
        .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pc_inc(pc_inc),
        .pc(pc), .flags_we(flags_we), .flags_in(flags_in), .cpsr(cpsr)
    );

    regfile_mp #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(3)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr16), .rd_data(rd_data16),
        .wr_en(wr_en16), .wr_addr(wr_addr16), .wr_data(wr_data16), .pc_inc(pc_inc16),
        .pc(pc16), .flags_we(flags_we16), .flags_in(flags_in16), .cpsr(cpsr16)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [31:0] pc;
        logic [31:0] cpsr;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: 16 architectural registers with index 15 holding the PC.
    logic [31:0] m_regs [16];
    logic [31:0] m_cpsr;

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
        m_cpsr = 32'h0;
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] idx);
        logic [31:0] v;
        v = (idx == 4'd15) ? m_regs[15] + 32'd8 : m_regs[idx];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr == idx)
            v = (idx == 4'd15) ? (wr_data & 32'hFFFF_FFFC) + 32'd8 : wr_data;
`endif
        return v;
    endfunction

    task automatic step(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic inc, input logic fwe, input logic [3:0] fl,
                        input logic [3:0] ra0, input logic [3:0] ra1);
        exp_t e;
        @(negedge clk);
        wr_en = we; wr_addr = wa; wr_data = wd; pc_inc = inc;
        flags_we = fwe; flags_in = fl; rd_addr = {ra1, ra0};
        #1;
        e.rd0  = m_read(ra0);
        e.rd1  = m_read(ra1);
        e.pc   = m_regs[15];
        e.cpsr = m_cpsr;
        exp_q.push_back(e);
        if (we && wa == 4'd15)  m_regs[15] = wd & 32'hFFFF_FFFC;
        else if (inc)           m_regs[15] = m_regs[15] + 32'd4;
        if (we && wa != 4'd15)  m_regs[wa] = wd;
        if (fwe)                m_cpsr = {fl, 28'h0};
    endtask

    task automatic idle(input logic [3:0] ra0, input logic [3:0] ra1);
        step(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'h0, ra0, ra1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rd0",  rd_data[31:0],  e.rd0);
                check("rd1",  rd_data[63:32], e.rd1);
                check("pc",   pc,             e.pc);
                check("cpsr", cpsr,           e.cpsr);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        reset_n = 1'b0;
        wr_en = 0; wr_addr = 0; wr_data = 0; pc_inc = 0; flags_we = 0; flags_in = 0;
        rd_addr = {4'd5, 4'd3};
        wr_en16 = 0; wr_addr16 = 0; wr_data16 = 0; pc_inc16 = 0; flags_we16 = 0; flags_in16 = 0;
        rd_addr16 = {3'd7, 3'd7, 3'd7};
        m_reset();
        #2;
        check("por_pc", pc, 32'h0);
        check("por_cpsr", cpsr, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Write/read and same-cycle read behaviour
        step(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 1'b0, 4'h0, 4'd3, 4'd3);
        idle(4'd3, 4'd3);
        // PC increment and offset read
        repeat (3) step(1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 4'h0, 4'd15, 4'd3);
        idle(4'd15, 4'd3);
        // PC wrap
        step(1'b1, 4'd15, 32'hFFFF_FFFC, 1'b0, 1'b0, 4'h0, 4'd15, 4'd15);
        step(1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 4'h0, 4'd15, 4'd0);
        idle(4'd15, 4'd0);
        // PC write beats pc_inc
        step(1'b1, 4'd15, 32'h0000_1003, 1'b1, 1'b0, 4'h0, 4'd15, 4'd1);
        idle(4'd15, 4'd1);
        // Flags with simultaneous PC write, then hold
        step(1'b1, 4'd15, 32'h0000_2000, 1'b0, 1'b1, 4'b1010, 4'd15, 4'd3);
        idle(4'd15, 4'd3);
        idle(4'd15, 4'd3);

        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        // Mid-cycle asynchronous reset with non-zero state beforehand
        step(1'b1, 4'd3, 32'h1234_5678, 1'b1, 1'b1, 4'b1111, 4'd3, 4'd5);
        step(1'b1, 4'd5, 32'h0000_0055, 1'b1, 1'b0, 4'h0, 4'd3, 4'd5);
        idle(4'd3, 4'd5);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_pc",   pc,             32'h0);
        check("arst_cpsr", cpsr,           32'h0);
        check("arst_rd0",  rd_data[31:0],  32'h0);
        check("arst_rd1",  rd_data[63:32], 32'h0);
        m_reset();
        @(negedge clk);
        reset_n = 1'b1;
        idle(4'd3, 4'd5);
        idle(4'd15, 4'd5);
        repeat (2) @(negedge clk);

        // 16-bit, 8-register, 3-port instance
        @(negedge clk);
        wr_en16 = 1'b1; wr_addr16 = 3'd7; wr_data16 = 16'h0101;
        rd_addr16 = {3'd7, 3'd7, 3'd7};
        #3;
`ifdef REGFILE_BYPASS_EN
        check("p16_same_rd0", 32'(rd_data16[15:0]), 32'h0108);
`else
        check("p16_same_rd0", 32'(rd_data16[15:0]), 32'h0008);
`endif
        check("p16_pc_before", 32'(pc16), 32'h0);
        @(negedge clk);
        wr_en16 = 1'b0;
        #3;
        check("p16_pc",   32'(pc16),              32'h0100);
        check("p16_rd0",  32'(rd_data16[15:0]),   32'h0108);
        check("p16_rd1",  32'(rd_data16[31:16]),  32'h0108);
        check("p16_rd2",  32'(rd_data16[47:32]),  32'h0108);
        check("p16_cpsr", 32'(cpsr16),            32'h0);
        @(negedge clk);
        wr_en16 = 1'b1; wr_addr16 = 3'd2; wr_data16 = 16'hBEEF;
        flags_we16 = 1'b1; flags_in16 = 4'b0101;
        @(negedge clk);
        wr_en16 = 1'b0; flags_we16 = 1'b0;
        rd_addr16 = {3'd2, 3'd7, 3'd2};
        #3;
        check("p16_r2_p0", 32'(rd_data16[15:0]),  32'hBEEF);
        check("p16_pc_p1", 32'(rd_data16[31:16]), 32'h0108);
        check("p16_r2_p2", 32'(rd_data16[47:32]), 32'hBEEF);
        check("p16_flags", 32'(cpsr16),           32'h5000);

        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
